// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect and decoder port.
// master = fetch unit side, slave = memory/decoder environment side.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   mem_rvalid;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_addr;
  logic                   dec_valid;
  logic                   dec_ready;
  logic [3:0]             dec_opcode;
  logic [3:0]             dec_rd;
  logic [3:0]             dec_rs;
  logic [7:0]             dec_imm;
  logic [ADDR_WIDTH-1:0]  dec_pc;
  logic                   halted;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata, mem_rvalid,
    input  redirect, redirect_addr,
    output dec_valid, dec_opcode, dec_rd, dec_rs, dec_imm, dec_pc, halted,
    input  dec_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata, mem_rvalid,
    output redirect, redirect_addr,
    input  dec_valid, dec_opcode, dec_rd, dec_rs, dec_imm, dec_pc, halted,
    output dec_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding memory reads, decoded-field FIFO, epoch-based redirect flush.
// Optional illegal-opcode trap (HALT state) enabled by defining FETCH_ILLEGAL_TRAP_EN.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int FIFO_DEPTH  = 2
) (
  input logic               clk,
  input logic               reset_n,
  instr_fetch_unit_if.master bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef FETCH_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {REQ, WAIT, HALT} state_t;
`else
  typedef enum logic [1:0] {REQ, WAIT} state_t;
`endif

  state_t                 state;
  logic                   req;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   epoch;
  logic                   req_epoch;

  logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;

  logic                   valid;
  logic                   resp;
  logic                   illegal;
  logic                   push;
  logic                   pop;
  logic                   credit;
  logic [INSTR_WIDTH-1:0] head;

  // A response counts only if its request was issued in the current epoch and no redirect is pending.
  assign resp   = (state == WAIT) && bus.mem_rvalid && (req_epoch == epoch) && !bus.redirect;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic halt_flag;
  assign illegal    = bus.mem_rdata[15:12] inside {[4'hA:4'hE]};
  assign bus.halted = halt_flag;
`else
  assign illegal    = 1'b0;
  assign bus.halted = 1'b0;
`endif
  assign push   = resp && !illegal;
  assign valid  = (count != '0);
  assign pop    = valid && bus.dec_ready && !bus.redirect;
  assign credit = (count < DEPTH_C);
  assign head   = fifo_instr[rd_ptr];

  assign bus.mem_req    = req;
  assign bus.mem_addr   = addr;
  assign bus.dec_valid  = valid;
  assign bus.dec_opcode = head[15:12];
  assign bus.dec_rd     = head[11:8];
  assign bus.dec_rs     = head[7:4];
  assign bus.dec_imm    = head[7:0];
  assign bus.dec_pc     = fifo_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= REQ;
      req       <= 1'b0;
      addr      <= '0;
      pc        <= '0;
      epoch     <= 1'b0;
      req_epoch <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      halt_flag <= 1'b0;
`endif
    end else begin
      if (bus.redirect) epoch <= ~epoch;
      case (state)
        REQ: begin
          if (req) begin
            if (bus.mem_ack) begin
              // Acked with a same-cycle redirect: tagged with the old epoch so the reply is dropped.
              req       <= 1'b0;
              state     <= WAIT;
              req_epoch <= epoch;
              pc        <= bus.redirect ? bus.redirect_addr : pc + ADDR_WIDTH'(1);
            end else if (bus.redirect) begin
              addr <= bus.redirect_addr;
              pc   <= bus.redirect_addr;
            end
          end else if (bus.redirect) begin
            req  <= 1'b1;
            addr <= bus.redirect_addr;
            pc   <= bus.redirect_addr;
          end else if (credit) begin
            req  <= 1'b1;
            addr <= pc;
          end
        end
        WAIT: begin
          if (bus.redirect) pc <= bus.redirect_addr;
          if (bus.mem_rvalid) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
            if (resp && illegal) begin
              state     <= HALT;
              halt_flag <= 1'b1;
            end else begin
              state <= REQ;
            end
`else
            state <= REQ;
`endif
          end
        end
`ifdef FETCH_ILLEGAL_TRAP_EN
        HALT: begin
          if (bus.redirect) begin
            state     <= REQ;
            halt_flag <= 1'b0;
            req       <= 1'b1;
            addr      <= bus.redirect_addr;
            pc        <= bus.redirect_addr;
          end
        end
`endif
        default: state <= REQ;
      endcase
    end
  end

  // The in-WAIT request address doubles as the fetch PC stored alongside the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= bus.mem_rdata;
        fifo_pc[wr_ptr]    <= addr;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder model, negedge scoreboard, one task per scenario.
module tb_instr_fetch_unit;
  localparam int AW = 8;
  localparam int IW = 16;
  localparam int DEPTH = 2;
`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic       vld;
    logic [7:0] pc;
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [7:0] imm;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();
  instr_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  logic [15:0] mem [256];
  ent_t        exp_q[$];
  ent_t        got_q[$];
  ent_t        want_q[$];
  logic [7:0]  ack_log[$];
  int          checks = 0;
  int          errors = 0;
  logic        busy = 1'b0;
  logic        stale = 1'b0;
  logic        mem_hold = 1'b0;
  int          mem_lat = 1;
  int          lat_cnt = 0;
  logic [7:0]  ack_addr = '0;

  function automatic ent_t expect_of(logic [7:0] a, logic [15:0] w);
    ent_t e;
    e.vld = 1'b1; e.pc = a; e.op = w[15:12]; e.rd = w[11:8]; e.rs = w[7:4]; e.imm = w[7:0];
    return e;
  endfunction

  function automatic logic pushes(logic [15:0] w);
    return !(TRAP && (w[15:12] >= 4'hA) && (w[15:12] <= 4'hE));
  endfunction

  // Memory responder: acks one cycle after mem_req is seen, data mem_lat cycles after the ack.
  initial begin
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      if (!reset_n) begin
        bus.mem_ack = 1'b0; busy = 1'b0;
      end else begin
        if (bus.mem_ack) begin bus.mem_ack = 1'b0; busy = 1'b1; lat_cnt = mem_lat; end
        if (busy) begin
          lat_cnt--;
          if (lat_cnt <= 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = mem[ack_addr]; busy = 1'b0; end
        end else if (bus.mem_req && !mem_hold) begin
          bus.mem_ack = 1'b1; ack_addr = bus.mem_addr;
        end
      end
    end
  end

  // Scoreboard: expected entries pushed on each accepted response, paired with observations on pop.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      exp_q.delete(); stale = 1'b0;
    end else begin
      if (bus.mem_req && bus.mem_ack) ack_log.push_back(bus.mem_addr);
      if (bus.redirect) begin
        exp_q.delete();
        if (bus.mem_rvalid) stale = 1'b0;
        if (busy || (bus.mem_req && bus.mem_ack)) stale = 1'b1;
      end else begin
        if (bus.dec_valid && bus.dec_ready) begin
          got_q.push_back('{1'b1, bus.dec_pc, bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm});
          if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
          else want_q.push_back('0);
        end
        if (bus.mem_rvalid) begin
          if (stale) stale = 1'b0;
          else if (pushes(bus.mem_rdata)) exp_q.push_back(expect_of(ack_addr, bus.mem_rdata));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    bus.redirect = 1'b0; bus.dec_ready = 1'b0; reset_n = 1'b0;
    tick(3);
    got_q.delete(); want_q.delete(); ack_log.delete();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [43:0] obs;
    tick(2);
    obs = {bus.mem_req, bus.mem_addr, bus.dec_valid, bus.dec_opcode, bus.dec_rd, bus.dec_rs,
           bus.dec_imm, bus.dec_pc, bus.halted};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs); end
    reset_n = 1'b1; bus.dec_ready = 1'b1;
    tick(8);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.dec_valid, bus.halted} !== 3'b000) begin
      errors++; $display("FAIL async_reset got req/valid/halt=%b want 000", {bus.mem_req, bus.dec_valid, bus.halted});
    end
  endtask

  task automatic test_basic();
    ent_t g, w;
    do_reset(); bus.dec_ready = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < 3; i++) tick(1);
    checks++;
    if (got_q.size() < 3) begin errors++; $display("FAIL basic_timeout got %0d pops want 3", got_q.size()); end
    else begin
      checks++;
      if ({got_q[0].op, got_q[0].rd, got_q[0].imm, got_q[0].pc} !== 24'h0_1_23_00) begin
        errors++; $display("FAIL basic_first got %h want 012300", {got_q[0].op, got_q[0].rd, got_q[0].imm, got_q[0].pc});
      end
      checks++;
      if ({got_q[1].op, got_q[1].rd, got_q[1].imm, got_q[1].pc} !== 24'h5_A_07_01) begin
        errors++; $display("FAIL basic_second got %h want 5A0701", {got_q[1].op, got_q[1].rd, got_q[1].imm, got_q[1].pc});
      end
      checks++;
      if ({got_q[2].op, got_q[2].pc} !== 12'hF_02) begin
        errors++; $display("FAIL basic_nop got %h want F02", {got_q[2].op, got_q[2].pc});
      end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL basic_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_backpressure();
    ent_t g, w;
    logic [27:0] snap;
    logic stable;
    do_reset();
    tick(20);
    checks++;
    if (ack_log.size() != 2) begin errors++; $display("FAIL bp_fetch_count got %0d want 2", ack_log.size()); end
    else begin
      checks++;
      if ({ack_log[0], ack_log[1]} !== 16'h0001) begin
        errors++; $display("FAIL bp_fetch_addr got %h want 0001", {ack_log[0], ack_log[1]});
      end
    end
    checks++;
    if ({bus.mem_req, bus.dec_valid, bus.dec_pc} !== {2'b01, 8'h00}) begin
      errors++; $display("FAIL bp_hold got req/valid/pc=%b%b/%h want 01/00", bus.mem_req, bus.dec_valid, bus.dec_pc);
    end
    snap = {bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc};
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if ({bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc} !== snap || !bus.dec_valid) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1 || ack_log.size() != 2) begin
      errors++; $display("FAIL bp_stable got stable=%b fetches=%0d want 1/2", stable, ack_log.size());
    end
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 100 && (got_q.size() < 2 || ack_log.size() < 3); i++) tick(1);
    checks++;
    if (got_q.size() < 2 || ack_log.size() < 3) begin errors++; $display("FAIL bp_timeout got %0d pops want 2", got_q.size()); end
    else begin
      checks++;
      if ({ack_log[2], got_q[0].pc, got_q[1].pc} !== 24'h02_00_01) begin
        errors++; $display("FAIL bp_resume got %h want 020001", {ack_log[2], got_q[0].pc, got_q[1].pc});
      end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL bp_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_redirect();
    ent_t g, w;
    do_reset(); mem_lat = 3; bus.dec_ready = 1'b1;
    for (int i = 0; i < 200 && ack_log.size() < 6; i++) tick(1);
    checks++;
    if (ack_log.size() < 6 || ack_log[5] !== 8'h05) begin
      errors++; $display("FAIL redir_setup got %0d fetches want addr 05 in flight", ack_log.size());
    end
    bus.redirect = 1'b1; bus.redirect_addr = 8'h40;
    tick(1);
    bus.redirect = 1'b0;
    checks++;
    if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got dec_valid=%b want 0", bus.dec_valid); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL redir_sb_pre got %h want %h", g, w); end
    end
    for (int i = 0; i < 200 && (got_q.size() < 1 || ack_log.size() < 7); i++) tick(1);
    checks++;
    if (got_q.size() < 1 || ack_log.size() < 7) begin errors++; $display("FAIL redir_timeout got %0d pops want 1", got_q.size()); end
    else begin
      checks++;
      if ({ack_log[6], got_q[0].pc} !== 16'h4040) begin
        errors++; $display("FAIL redir_target got addr/pc=%h want 4040", {ack_log[6], got_q[0].pc});
      end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL redir_sb got %h want %h", g, w); end
    end
    mem_lat = 1;
  endtask

  task automatic test_wrap();
    ent_t g, w;
    do_reset(); bus.dec_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_addr = 8'hFF;
    tick(1);
    bus.redirect = 1'b0;
    for (int i = 0; i < 100 && got_q.size() < 2; i++) tick(1);
    checks++;
    if (got_q.size() < 2) begin errors++; $display("FAIL wrap_timeout got %0d pops want 2", got_q.size()); end
    else begin
      checks++;
      if ({got_q[0].pc, got_q[1].pc} !== 16'hFF00) begin
        errors++; $display("FAIL wrap_pc got %h want FF00", {got_q[0].pc, got_q[1].pc});
      end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL wrap_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_redirect_pop();
    ent_t g, w;
    do_reset();
    tick(20);
    checks++;
    if ({bus.dec_valid, bus.mem_req} !== 2'b10) begin
      errors++; $display("FAIL rp_full got valid/req=%b%b want 10", bus.dec_valid, bus.mem_req);
    end
    bus.dec_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_addr = 8'h80;
    tick(1);
    bus.redirect = 1'b0;
    checks++;
    if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rp_flush got dec_valid=%b want 0", bus.dec_valid); end
    for (int i = 0; i < 100 && got_q.size() < 3; i++) tick(1);
    checks++;
    if (got_q.size() < 3) begin errors++; $display("FAIL rp_timeout got %0d pops want 3", got_q.size()); end
    else begin
      checks++;
      if ({got_q[0].pc, got_q[1].pc, got_q[2].pc} !== 24'h808182) begin
        errors++; $display("FAIL rp_order got %h want 808182", {got_q[0].pc, got_q[1].pc, got_q[2].pc});
      end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL rp_sb got %h want %h", g, w); end
    end
  endtask

  task automatic test_illegal();
    ent_t g, w;
    mem[3] = 16'hA000;
    do_reset(); bus.dec_ready = 1'b1;
    for (int i = 0; i < 100 && ack_log.size() < 4; i++) tick(1);
    tick(12);
`ifdef FETCH_ILLEGAL_TRAP_EN
    checks++;
    if ({bus.halted, bus.mem_req} !== 2'b10 || ack_log.size() != 4) begin
      errors++; $display("FAIL ill_halt got halted/req=%b%b fetches=%0d want 10/4", bus.halted, bus.mem_req, ack_log.size());
    end
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL ill_drain got %0d pops want 3", got_q.size()); end
    else begin
      checks++;
      if ({got_q[0].pc, got_q[1].pc, got_q[2].pc} !== 24'h000102) begin
        errors++; $display("FAIL ill_drain_pc got %h want 000102", {got_q[0].pc, got_q[1].pc, got_q[2].pc});
      end
    end
    bus.redirect = 1'b1; bus.redirect_addr = 8'h00;
    tick(1);
    bus.redirect = 1'b0;
    checks++;
    if (bus.halted !== 1'b0) begin errors++; $display("FAIL ill_exit got halted=%b want 0", bus.halted); end
    for (int i = 0; i < 50 && ack_log.size() < 5; i++) tick(1);
    checks++;
    if (ack_log.size() < 5 || ack_log[4] !== 8'h00) begin
      errors++; $display("FAIL ill_refetch got %0d fetches want addr 00 next", ack_log.size());
    end
`else
    checks++;
    if (got_q.size() < 4) begin errors++; $display("FAIL ill_timeout got %0d pops want 4", got_q.size()); end
    else begin
      checks++;
      if ({got_q[3].op, got_q[3].pc, bus.halted} !== {4'hA, 8'h03, 1'b0}) begin
        errors++; $display("FAIL ill_pass got op/pc/halted=%h/%h/%b want A/03/0", got_q[3].op, got_q[3].pc, bus.halted);
      end
    end
`endif
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL ill_sb got %h want %h", g, w); end
    end
    mem[3] = {4'(3 % 10), 4'(3), 8'(3 ^ 8'h5C)};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t g, w;
    for (int i = 0; i < 256; i++) mem[i] = {4'(i % 10), 4'(i), 8'(i ^ 8'h5C)};
    mem[0] = 16'h0123; mem[1] = 16'h5A07; mem[2] = 16'hF0F0;
    bus.redirect = 1'b0; bus.redirect_addr = '0; bus.dec_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_pop();
    test_illegal();
    mem_hold = 1'b1;
    tick(20);
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front(); checks++;
      if (g !== w) begin errors++; $display("FAIL tail_sb got %h want %h", g, w); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover got %0d expected entries undelivered want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
